// File: rtl/dut_mul_share_arb_if.sv
// Request/response bundle for dut_mul_share_arb: per-requester valid/ready operand ports
// and the tagged result port.
interface dut_mul_share_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned A_W     = 12,
    parameter int unsigned B_W     = 10,
    parameter int unsigned P_W     = 22,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [P_W-1:0]         rsp_p;
    logic [NUM_REQ-1:0]     rsp_vec;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_vec, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_p, rsp_vec, busy
    );
endinterface

// File: rtl/dut_mul_share_arb.sv
// One unsigned A_W x B_W multiplier shared round-robin between NUM_REQ requesters.
// Fixed MUL_LAT pipeline, results tagged with requester ID; ap_ce freezes all state.
module dut_mul_share_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned A_W     = 12,
    parameter int unsigned B_W     = 10,
    parameter int unsigned P_W     = 22,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned ID_W    = 2
) (
    input logic                ap_clk,
    input logic                ap_rst_n,
    input logic                ap_ce,
    dut_mul_share_arb_if.slave bus
);
    localparam int unsigned IdWExp = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

    if (P_W != A_W + B_W) begin : g_bad_p_w
        $error("P_W must equal A_W + B_W");
    end
    if (ID_W != IdWExp) begin : g_bad_id_w
        $error("ID_W must equal max(1, clog2(NUM_REQ))");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (MUL_LAT < 1) begin : g_bad_lat
        $error("MUL_LAT must be at least 1");
    end

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [NUM_REQ-1:0] ready;
    logic [A_W-1:0]     a_sel;
    logic [B_W-1:0]     b_sel;
    int unsigned        idx;

    // Search from ptr upward with wrap; held off entirely while frozen or in reset.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_any && bus.req_valid[idx[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[ID_W-1:0];
            end
        end
        gnt_any = gnt_any & ap_ce & ap_rst_n;
    end

    always_comb begin
        ready = '0;
        if (gnt_any) begin
            ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    assign a_sel = bus.req_a[gnt_id*A_W +: A_W];
    assign b_sel = bus.req_b[gnt_id*B_W +: B_W];

    logic            v0_q;
    logic [A_W-1:0]  a0_q;
    logic [B_W-1:0]  b0_q;
    logic [ID_W-1:0] id0_q;
    logic [P_W-1:0]  prod;

    // Operand/ID registers only load on a handshake so the result port keeps its last value.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q <= '0;
            v0_q  <= 1'b0;
            a0_q  <= '0;
            b0_q  <= '0;
            id0_q <= '0;
        end else if (ap_ce) begin
            ptr_q <= ptr_d;
            v0_q  <= gnt_any;
            if (gnt_any) begin
                a0_q  <= a_sel;
                b0_q  <= b_sel;
                id0_q <= gnt_id;
            end
        end
    end

    assign prod = P_W'(a0_q) * P_W'(b0_q);

    logic            last_v;
    logic [P_W-1:0]  last_p;
    logic [ID_W-1:0] last_id;
    logic            tail_busy;

    if (MUL_LAT == 1) begin : g_lat1
        assign last_v    = v0_q;
        assign last_p    = prod;
        assign last_id   = id0_q;
        assign tail_busy = 1'b0;
    end else begin : g_latn
        localparam int unsigned NumStages = MUL_LAT - 1;

        logic [NumStages-1:0] v_q;
        logic [P_W-1:0]       p_q  [NumStages];
        logic [ID_W-1:0]      id_q [NumStages];

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                v_q <= '0;
                for (int unsigned s = 0; s < NumStages; s++) begin
                    p_q[s]  <= '0;
                    id_q[s] <= '0;
                end
            end else if (ap_ce) begin
                v_q[0] <= v0_q;
                if (v0_q) begin
                    p_q[0]  <= prod;
                    id_q[0] <= id0_q;
                end
                for (int unsigned s = 1; s < NumStages; s++) begin
                    v_q[s] <= v_q[s-1];
                    if (v_q[s-1]) begin
                        p_q[s]  <= p_q[s-1];
                        id_q[s] <= id_q[s-1];
                    end
                end
            end
        end

        assign last_v    = v_q[NumStages-1];
        assign last_p    = p_q[NumStages-1];
        assign last_id   = id_q[NumStages-1];
        assign tail_busy = |v_q;
    end

    logic               rsp_valid;
    logic [NUM_REQ-1:0] rsp_vec;

    // Gating with ap_ce keeps a frozen result from being consumed twice.
    assign rsp_valid = last_v & ap_ce;

    always_comb begin
        rsp_vec = '0;
        if (rsp_valid) begin
            rsp_vec[last_id] = 1'b1;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = last_id;
    assign bus.rsp_p     = last_p;
    assign bus.rsp_vec   = rsp_vec;
    assign bus.busy      = v0_q | tail_busy;
endmodule

// File: tb/tb_dut_mul_share_arb.sv
// Directed bench for dut_mul_share_arb: a cycle table for arbitration/pipeline/ce behaviour
// plus hand sequences for async reset, a full-range product and a sole back-to-back requester.
module tb_dut_mul_share_arb;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned A_W     = 12;
    localparam int unsigned B_W     = 10;
    localparam int unsigned P_W     = 22;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned ID_W    = 2;
    localparam int          NROWS   = 27;

    localparam logic [47:0] AAll = {12'd4, 12'd3, 12'd2, 12'd1};
    localparam logic [39:0] BAll = {10'd10, 10'd10, 10'd10, 10'd10};

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    logic ap_ce;
    int   checks   = 0;
    int   failures = 0;

    dut_mul_share_arb_if #(
        .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .ID_W(ID_W)
    ) bus ();

    dut_mul_share_arb #(
        .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LAT(MUL_LAT), .ID_W(ID_W)
    ) u_dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .ap_ce   (ap_ce),
        .bus     (bus)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [3:0]  vld;
        logic        ce;
        logic [47:0] a;
        logic [39:0] b;
        logic [3:0]  rdy;
        logic        rv;
        logic [1:0]  rid;
        logic [21:0] rp;
        logic        busy;
    } vec_t;

    vec_t tbl [NROWS];

    function automatic vec_t mk(input logic [3:0] vld, input logic ce, input logic [3:0] rdy,
                                input logic rv, input logic [1:0] rid, input logic [21:0] rp,
                                input logic busy);
        vec_t v;
        v.vld  = vld;
        v.ce   = ce;
        v.a    = AAll;
        v.b    = BAll;
        v.rdy  = rdy;
        v.rv   = rv;
        v.rid  = rid;
        v.rp   = rp;
        v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] rdy, input logic rv,
                           input logic [1:0] rid, input logic [21:0] rp, input logic busy);
        logic [3:0] vec;
        vec = rv ? (4'b0001 << rid) : 4'b0000;
        chk($sformatf("%s req_ready", tag), 32'(bus.req_ready), 32'(rdy));
        chk($sformatf("%s rsp_valid", tag), 32'(bus.rsp_valid), 32'(rv));
        chk($sformatf("%s rsp_id", tag), 32'(bus.rsp_id), 32'(rid));
        chk($sformatf("%s rsp_p", tag), 32'(bus.rsp_p), 32'(rp));
        chk($sformatf("%s rsp_vec", tag), 32'(bus.rsp_vec), 32'(vec));
        chk($sformatf("%s busy", tag), 32'(bus.busy), 32'(busy));
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [47:0] a_v;
        logic [39:0] b_v;

        // Full rotation, drain, then 1&3 from ptr=2, then a 3-cycle ce freeze.
        tbl[0]  = mk(4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 22'd0,  1'b0);
        tbl[1]  = mk(4'hF, 1'b1, 4'b0010, 1'b0, 2'd0, 22'd0,  1'b1);
        tbl[2]  = mk(4'hF, 1'b1, 4'b0100, 1'b1, 2'd0, 22'd10, 1'b1);
        tbl[3]  = mk(4'hF, 1'b1, 4'b1000, 1'b1, 2'd1, 22'd20, 1'b1);
        tbl[4]  = mk(4'hF, 1'b1, 4'b0001, 1'b1, 2'd2, 22'd30, 1'b1);
        tbl[5]  = mk(4'hF, 1'b1, 4'b0010, 1'b1, 2'd3, 22'd40, 1'b1);
        tbl[6]  = mk(4'hF, 1'b1, 4'b0100, 1'b1, 2'd0, 22'd10, 1'b1);
        tbl[7]  = mk(4'hF, 1'b1, 4'b1000, 1'b1, 2'd1, 22'd20, 1'b1);
        tbl[8]  = mk(4'h0, 1'b1, 4'b0000, 1'b1, 2'd2, 22'd30, 1'b1);
        tbl[9]  = mk(4'h0, 1'b1, 4'b0000, 1'b1, 2'd3, 22'd40, 1'b1);
        tbl[10] = mk(4'h0, 1'b1, 4'b0000, 1'b0, 2'd3, 22'd40, 1'b0);
        tbl[11] = mk(4'h2, 1'b1, 4'b0010, 1'b0, 2'd3, 22'd40, 1'b0);
        tbl[12] = mk(4'hA, 1'b1, 4'b1000, 1'b0, 2'd3, 22'd40, 1'b1);
        tbl[13] = mk(4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 22'd20, 1'b1);
        tbl[14] = mk(4'hA, 1'b1, 4'b1000, 1'b1, 2'd3, 22'd40, 1'b1);
        tbl[15] = mk(4'hA, 1'b1, 4'b0010, 1'b1, 2'd1, 22'd20, 1'b1);
        tbl[16] = mk(4'h0, 1'b1, 4'b0000, 1'b1, 2'd3, 22'd40, 1'b1);
        tbl[17] = mk(4'h0, 1'b1, 4'b0000, 1'b1, 2'd1, 22'd20, 1'b1);
        tbl[18] = mk(4'h0, 1'b1, 4'b0000, 1'b0, 2'd1, 22'd20, 1'b0);
        tbl[19] = mk(4'h1, 1'b1, 4'b0001, 1'b0, 2'd1, 22'd20, 1'b0);
        tbl[20] = mk(4'h2, 1'b1, 4'b0010, 1'b0, 2'd1, 22'd20, 1'b1);
        tbl[21] = mk(4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 22'd10, 1'b1);
        tbl[22] = mk(4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 22'd10, 1'b1);
        tbl[23] = mk(4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 22'd10, 1'b1);
        tbl[24] = mk(4'h0, 1'b1, 4'b0000, 1'b1, 2'd0, 22'd10, 1'b1);
        tbl[25] = mk(4'h0, 1'b1, 4'b0000, 1'b1, 2'd1, 22'd20, 1'b1);
        tbl[26] = mk(4'h0, 1'b1, 4'b0000, 1'b0, 2'd1, 22'd20, 1'b0);

        ap_rst_n      = 1'b0;
        ap_ce         = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_a     = AAll;
        bus.req_b     = BAll;
        tick();
        tick();
        chk_out("reset", 4'b0000, 1'b0, 2'd0, 22'd0, 1'b0);
        ap_rst_n = 1'b1;

        for (int i = 0; i < NROWS; i++) begin
            bus.req_valid = tbl[i].vld;
            ap_ce         = tbl[i].ce;
            bus.req_a     = tbl[i].a;
            bus.req_b     = tbl[i].b;
            #1;
            chk_out($sformatf("row%0d", i), tbl[i].rdy, tbl[i].rv, tbl[i].rid, tbl[i].rp,
                    tbl[i].busy);
            tick();
        end

        // Asynchronous reset with requests in flight (ptr is 2 here).
        bus.req_valid = 4'hF;
        #1;
        chk("rst_pre grant", 32'(bus.req_ready), 32'(4'b0100));
        tick();
        #1;
        chk("rst_pre busy", 32'(bus.busy), 32'(1'b1));
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk_out("rst_async", 4'b0000, 1'b0, 2'd0, 22'd0, 1'b0);
        bus.req_valid = 4'h0;
        tick();
        ap_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_out($sformatf("rst_post%0d", i), 4'b0000, 1'b0, 2'd0, 22'd0, 1'b0);
            tick();
        end
        bus.req_valid = 4'hF;
        #1;
        chk("rst_ptr grant", 32'(bus.req_ready), 32'(4'b0001));
        bus.req_valid = 4'h0;
        tick();

        // Full-range operands from requester 2.
        a_v             = '0;
        b_v             = '0;
        a_v[24 +: 12]   = 12'd4095;
        b_v[20 +: 10]   = 10'd1023;
        bus.req_a       = a_v;
        bus.req_b       = b_v;
        bus.req_valid   = 4'b0100;
        #1;
        chk_out("single_iss", 4'b0100, 1'b0, 2'd0, 22'd0, 1'b0);
        tick();
        bus.req_valid = 4'h0;
        #1;
        chk_out("single_c1", 4'b0000, 1'b0, 2'd0, 22'd0, 1'b1);
        tick();
        #1;
        chk_out("single_c2", 4'b0000, 1'b1, 2'd2, 22'd4189185, 1'b1);
        tick();
        #1;
        chk_out("single_c3", 4'b0000, 1'b0, 2'd2, 22'd4189185, 1'b0);

        // Sole requester 1 granted back to back: a = 0, 5, 0 with b = 1023.
        a_v           = '0;
        b_v           = '0;
        b_v[10 +: 10] = 10'd1023;
        bus.req_b     = b_v;
        bus.req_a     = a_v;
        bus.req_valid = 4'b0010;
        #1;
        chk_out("sole_c0", 4'b0010, 1'b0, 2'd2, 22'd4189185, 1'b0);
        tick();
        a_v[12 +: 12] = 12'd5;
        bus.req_a     = a_v;
        #1;
        chk_out("sole_c1", 4'b0010, 1'b0, 2'd2, 22'd4189185, 1'b1);
        tick();
        a_v[12 +: 12] = 12'd0;
        bus.req_a     = a_v;
        #1;
        chk_out("sole_c2", 4'b0010, 1'b1, 2'd1, 22'd0, 1'b1);
        tick();
        bus.req_valid = 4'h0;
        #1;
        chk_out("sole_c3", 4'b0000, 1'b1, 2'd1, 22'd5115, 1'b1);
        tick();
        #1;
        chk_out("sole_c4", 4'b0000, 1'b1, 2'd1, 22'd0, 1'b1);
        tick();
        #1;
        chk_out("sole_c5", 4'b0000, 1'b0, 2'd1, 22'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
